// File: rtl/spi_word_receiver.sv
// SPI mode-0 slave that deserialises MSB-first command words into a small
// first-word-fall-through FIFO with a valid/ready consumer port.
module spi_word_receiver #(
    parameter int unsigned WORD_BITS   = 24,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_spi_clk,
    input  logic                          i_spi_cs,
    input  logic                          i_spi_mosi,
    output logic [WORD_BITS-1:0]          o_word_data,
    output logic                          o_word_valid,
    input  logic                          i_word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    output logic                          o_frame_err,
    input  logic                          i_clear_err
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(WORD_BITS);

    typedef enum logic {StIdle, StActive} state_t;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_d, cs_d;
    logic                   sck_rise_q, cs_fall_q, cs_rise_q, mosi_q;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [WORD_BITS-1:0]   shreg_q;
    logic                   push_q;

    logic [WORD_BITS-1:0]   mem [FIFO_DEPTH];
    logic [AW:0]            wptr_q, rptr_q, wptr_d, rptr_d;
    logic                   pop, full, accept;
    logic [WORD_BITS-1:0]   data_d;

    // CS sync resets low so a CS already low at reset release is not seen as a falling edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sck_sync   <= '0;
            cs_sync    <= '0;
            mosi_sync  <= '0;
            sck_d      <= 1'b0;
            cs_d       <= 1'b0;
            sck_rise_q <= 1'b0;
            cs_fall_q  <= 1'b0;
            cs_rise_q  <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            sck_sync   <= {sck_sync[SYNC_STAGES-2:0], i_spi_clk};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], i_spi_cs};
            mosi_sync  <= {mosi_sync[SYNC_STAGES-2:0], i_spi_mosi};
            sck_d      <= sck_sync[SYNC_STAGES-1];
            cs_d       <= cs_sync[SYNC_STAGES-1];
            sck_rise_q <= sck_sync[SYNC_STAGES-1] & ~sck_d;
            cs_fall_q  <= ~cs_sync[SYNC_STAGES-1] & cs_d;
            cs_rise_q  <= cs_sync[SYNC_STAGES-1] & ~cs_d;
            mosi_q     <= mosi_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            shreg_q     <= '0;
            push_q      <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            push_q      <= 1'b0;
            o_frame_err <= o_frame_err & ~i_clear_err;
            case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    if (cs_fall_q) begin
                        state_q <= StActive;
                    end
                end
                StActive: begin
                    if (cs_rise_q) begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        if (cnt_q != '0) begin
                            o_frame_err <= 1'b1;
                        end
                    end else if (sck_rise_q) begin
                        shreg_q <= {shreg_q[WORD_BITS-2:0], mosi_q};
                        if (cnt_q == CW'(WORD_BITS - 1)) begin
                            cnt_q  <= '0;
                            push_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        pop    = o_word_valid & i_word_ready;
        full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        accept = push_q & (~full | pop);
        wptr_d = accept ? wptr_q + 1'b1 : wptr_q;
        rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
        // The word being written this cycle becomes the head if it lands on the next read slot.
        if (accept && (wptr_q[AW-1:0] == rptr_d[AW-1:0])) begin
            data_d = shreg_q;
        end else begin
            data_d = mem[rptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge i_clk) begin
        if (accept) begin
            mem[wptr_q[AW-1:0]] <= shreg_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            o_word_valid <= 1'b0;
            o_word_data  <= '0;
            o_fifo_level <= '0;
            o_overflow   <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            o_word_valid <= wptr_d != rptr_d;
            o_word_data  <= data_d;
            o_fifo_level <= wptr_d - rptr_d;
            o_overflow   <= (o_overflow & ~i_clear_err) | (push_q & ~accept);
        end
    end

endmodule

// File: tb/tb_spi_word_receiver.sv
// Directed bench for spi_word_receiver: latency, FIFO fill/overflow, frame errors,
// reset mid-frame and SCK activity with CS high.
module tb_spi_word_receiver;

    logic        clk = 1'b0;
    logic        rst, sck, cs, mosi, ready, clear;
    logic [23:0] word_data;
    logic        word_valid, overflow, frame_err;
    logic [3:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spi_word_receiver dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_spi_clk    (sck),
        .i_spi_cs     (cs),
        .i_spi_mosi   (mosi),
        .o_word_data  (word_data),
        .o_word_valid (word_valid),
        .i_word_ready (ready),
        .o_fifo_level (level),
        .o_overflow   (overflow),
        .o_frame_err  (frame_err),
        .i_clear_err  (clear)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic spi_bit_rise(input logic b);
        @(negedge clk) mosi = b;
        repeat (3) @(negedge clk);
        sck = 1'b1;
    endtask

    task automatic spi_bit_fall();
        repeat (4) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [23:0] v, input int n);
        for (int i = 23; i > 23 - n; i--) begin
            spi_bit_rise(v[i]);
            spi_bit_fall();
        end
    endtask

    task automatic cs_low();
        @(negedge clk) cs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (3) @(negedge clk);
        cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sck = 1'b0; cs = 1'b1; mosi = 1'b0; ready = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_valid", {31'd0, word_valid}, 32'd0);
        check("rst_data", {8'd0, word_data}, 32'd0);
        check("rst_level", {28'd0, level}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Single word, latency SYNC_STAGES+2 = 4 cycles from first sample of last SCK high.
        ready = 1'b1;
        cs_low();
        send_bits(24'h812345, 23);
        spi_bit_rise(1'b1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 4) check("lat_before", {31'd0, word_valid}, 32'd0);
            if (k == 5) begin
                check("lat_valid", {31'd0, word_valid}, 32'd1);
                check("lat_data", {8'd0, word_data}, 32'h812345);
            end
            if (k == 6) check("lat_pulse_end", {31'd0, word_valid}, 32'd0);
        end
        sck = 1'b0;
        cs_high();
        check("single_ovf", {31'd0, overflow}, 32'd0);
        check("single_ferr", {31'd0, frame_err}, 32'd0);

        // Ten words in one frame with no consumer: two dropped.
        ready = 1'b0;
        cs_low();
        for (int w = 1; w <= 10; w++) send_bits(24'(w), 24);
        cs_high();
        check("fill_level", {28'd0, level}, 32'd8);
        check("fill_ovf", {31'd0, overflow}, 32'd1);
        check("fill_ferr", {31'd0, frame_err}, 32'd0);
        ready = 1'b1;
        for (int w = 1; w <= 8; w++) begin
            check("drain_data", {8'd0, word_data}, 32'(w));
            @(negedge clk);
        end
        check("drain_valid", {31'd0, word_valid}, 32'd0);
        check("drain_level", {28'd0, level}, 32'd0);
        ready = 1'b0;
        pulse_clear();
        @(negedge clk);
        check("ovf_cleared", {31'd0, overflow}, 32'd0);

        // Full FIFO, pop in the same cycle the ninth word is pushed.
        cs_low();
        for (int w = 1; w <= 8; w++) send_bits(24'h000100 + 24'(w), 24);
        send_bits(24'h777777, 23);
        spi_bit_rise(1'b1);
        repeat (4) @(negedge clk);
        check("full_level_pre", {28'd0, level}, 32'd8);
        ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        check("full_level", {28'd0, level}, 32'd8);
        check("full_ovf", {31'd0, overflow}, 32'd0);
        check("full_head", {8'd0, word_data}, 32'h000102);
        spi_bit_fall();
        cs_high();
        ready = 1'b1;
        for (int w = 2; w <= 9; w++) begin
            check("full_drain", {8'd0, word_data}, (w == 9) ? 32'h777777 : 32'h100 + 32'(w));
            @(negedge clk);
        end
        check("full_empty", {31'd0, word_valid}, 32'd0);
        ready = 1'b0;

        // Partial frame then a clean word.
        cs_low();
        send_bits(24'h5A5A5A, 13);
        cs_high();
        check("ferr_set", {31'd0, frame_err}, 32'd1);
        check("ferr_no_word", {31'd0, word_valid}, 32'd0);
        cs_low();
        send_bits(24'h900000, 24);
        cs_high();
        check("ferr_level", {28'd0, level}, 32'd1);
        check("ferr_data", {8'd0, word_data}, 32'h900000);
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;
        check("ferr_popped", {31'd0, word_valid}, 32'd0);
        pulse_clear();
        check("ferr_cleared", {31'd0, frame_err}, 32'd0);
        // Error event lands at the same edge as the clear pulse: set wins.
        cs_low();
        send_bits(24'hFFFFFF, 5);
        repeat (3) @(negedge clk);
        cs = 1'b1;
        repeat (3) @(negedge clk);
        clear = 1'b1;
        @(negedge clk) clear = 1'b0;
        check("ferr_set_wins", {31'd0, frame_err}, 32'd1);
        repeat (4) @(negedge clk);
        pulse_clear();
        check("ferr_clear2", {31'd0, frame_err}, 32'd0);

        // Reset mid-word with three words queued; CS stays low through release.
        cs_low();
        for (int w = 0; w < 3; w++) send_bits(24'h0F0F00 + 24'(w), 24);
        send_bits(24'hC00000, 10);
        check("pre_rst_level", {28'd0, level}, 32'd3);
        @(negedge clk) rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, word_valid}, 32'd0);
        check("mid_rst_data", {8'd0, word_data}, 32'd0);
        check("mid_rst_level", {28'd0, level}, 32'd0);
        check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send_bits(24'h555555, 24);
        cs_high();
        check("rst_cs_low_none", {31'd0, word_valid}, 32'd0);
        check("rst_cs_low_ferr", {31'd0, frame_err}, 32'd0);
        cs_low();
        send_bits(24'h00ABCD, 24);
        cs_high();
        check("post_rst_level", {28'd0, level}, 32'd1);
        check("post_rst_data", {8'd0, word_data}, 32'h00ABCD);
        @(negedge clk) ready = 1'b1;
        @(negedge clk) ready = 1'b0;

        // SCK activity with CS high is ignored.
        send_bits(24'hFFFFFF, 24);
        repeat (6) @(negedge clk);
        check("csh_valid", {31'd0, word_valid}, 32'd0);
        check("csh_ovf", {31'd0, overflow}, 32'd0);
        check("csh_ferr", {31'd0, frame_err}, 32'd0);
        cs_low();
        send_bits(24'h3C5A96, 24);
        cs_high();
        check("csh_level", {28'd0, level}, 32'd1);
        check("csh_data", {8'd0, word_data}, 32'h3C5A96);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
